// File: rtl/pulse_len_gen.sv
// -----------------------------------------------------------------------------
// pulse_len_gen
// Light-pulse width generator. It sits after the inter-pulse delay stage, which
// supplies the launch level. A registered 0->1 transition on PL_launch starts a
// pulse. PL_out is then high for pulse_len * scale clock cycles, where scale is
// 1, 100 or 100000 as selected by pl_mlt. End_Flg_PL reports completion to the
// sequencer and is held until PL_launch returns low.
//
// Optional feature (macro PL_HOLDOFF_EN):
//   When defined, a HOLD state and a 20-bit holdoff counter are compiled in.
//   After every pulse or abort, the design waits HOLDOFF cycles before it
//   accepts another start. This guarantees a minimum PL_out low time. The
//   HOLDOFF parameter is always declared but only used in this build.
//
// Ports:
//   clk_Pulse   in   1   system clock (same domain as the delay stage)
//   rst_n       in   1   asynchronous active-low reset
//   PL_launch   in   1   launch level from the delay stage
//   pulse_len   in  17   pulse length in scaled units
//   pl_mlt      in   5   scale code: 1 -> x1, 2 -> x100, other -> x100000
//   PL_out      out  1   light-pulse gate
//   End_Flg_PL  out  1   pulse completed, held until PL_launch is low
//   busy        out  1   high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module pulse_len_gen
   #(parameter int unsigned HOLDOFF = 1000)
   (
   input  logic        clk_Pulse,
   input  logic        rst_n,
   input  logic        PL_launch,
   input  logic [16:0] pulse_len,
   input  logic [4:0]  pl_mlt,
   output logic        PL_out,
   output logic        End_Flg_PL,
   output logic        busy
);

`ifdef PL_HOLDOFF_EN
   typedef enum logic [1:0] {IDLE, PULSE, DONE, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, PULSE, DONE} state_t;
`endif

   state_t      state, state_next, leave_state;
   logic        launch_d;
   logic        armed;
   logic        start;
   logic        last_cycle;
   logic        cnt1_wrap;
   logic [16:0] scl_sel;
   logic [16:0] len_q, len_next;
   logic [16:0] scl_q, scl_next;
   logic [16:0] cnt1, cnt1_next;
   logic [16:0] cnt2, cnt2_next;
   logic        pl_next, end_next;
`ifdef PL_HOLDOFF_EN
   logic [19:0] hold_cnt, hold_next;
`endif

   // armed is set once PL_launch has been sampled low since reset. Without it,
   // the cleared launch_d after reset would make a level that is still high
   // look like a fresh rising edge.
   assign start = PL_launch & ~launch_d & armed;

   // cnt1 runs 0..scl_q-1 and cnt2 runs 0..len_q-1. Together they hold the
   // flattened cycle index inside the pulse. The last cycle is where both
   // counters sit at their final value.
   assign cnt1_wrap  = (cnt1 == scl_q - 17'd1);
   assign last_cycle = cnt1_wrap && (cnt2 == len_q - 17'd1);

   // The state entered after DONE or an abort depends on the holdoff build.
`ifdef PL_HOLDOFF_EN
   assign leave_state = HOLD;
`else
   assign leave_state = IDLE;
`endif

   // Decode the scale code into the cycle count of one length unit.
   always_comb begin
      case (pl_mlt)
         5'd1:    scl_sel = 17'd1;
         5'd2:    scl_sel = 17'd100;
         default: scl_sel = 17'd100000;
      endcase
   end

   // Next-state and next-output logic. All outputs are registered, so this
   // block computes their values for the coming edge. An abort wins over
   // completion in the same cycle, so no flag is set in that case. Rising
   // edges seen in HOLD only update launch_d, so they are dropped.
   always_comb begin
      state_next = state;
      pl_next    = PL_out;
      end_next   = End_Flg_PL;
      cnt1_next  = cnt1;
      cnt2_next  = cnt2;
      len_next   = len_q;
      scl_next   = scl_q;
`ifdef PL_HOLDOFF_EN
      hold_next  = '0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               len_next  = pulse_len;
               scl_next  = scl_sel;
               cnt1_next = '0;
               cnt2_next = '0;
               if (pulse_len != 17'd0) begin
                  state_next = PULSE;
                  pl_next    = 1'b1;
               end else begin
                  state_next = DONE;
                  end_next   = 1'b1;
               end
            end
         end
         PULSE: begin
            if (!PL_launch) begin
               pl_next    = 1'b0;
               cnt1_next  = '0;
               cnt2_next  = '0;
               state_next = leave_state;
            end else if (last_cycle) begin
               pl_next    = 1'b0;
               end_next   = 1'b1;
               cnt1_next  = '0;
               cnt2_next  = '0;
               state_next = DONE;
            end else if (cnt1_wrap) begin
               cnt1_next = '0;
               cnt2_next = cnt2 + 17'd1;
            end else begin
               cnt1_next = cnt1 + 17'd1;
            end
         end
         DONE: begin
            if (!PL_launch) begin
               end_next   = 1'b0;
               state_next = leave_state;
            end
         end
`ifdef PL_HOLDOFF_EN
         HOLD: begin
            if (32'(hold_cnt) + 32'd1 >= HOLDOFF) begin
               state_next = IDLE;
            end else begin
               hold_next = hold_cnt + 20'd1;
            end
         end
`endif
         default: begin
            state_next = IDLE;
            pl_next    = 1'b0;
            end_next   = 1'b0;
         end
      endcase
   end

   // State and output registers. The asynchronous reset drops PL_out at once
   // if it arrives in the middle of a pulse.
   always_ff @(posedge clk_Pulse or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         launch_d   <= 1'b0;
         armed      <= 1'b0;
         len_q      <= '0;
         scl_q      <= '0;
         cnt1       <= '0;
         cnt2       <= '0;
         PL_out     <= 1'b0;
         End_Flg_PL <= 1'b0;
         busy       <= 1'b0;
`ifdef PL_HOLDOFF_EN
         hold_cnt   <= '0;
`endif
      end else begin
         state      <= state_next;
         launch_d   <= PL_launch;
         armed      <= armed | ~PL_launch;
         len_q      <= len_next;
         scl_q      <= scl_next;
         cnt1       <= cnt1_next;
         cnt2       <= cnt2_next;
         PL_out     <= pl_next;
         End_Flg_PL <= end_next;
         busy       <= (state_next != IDLE);
`ifdef PL_HOLDOFF_EN
         hold_cnt   <= hold_next;
`endif
      end
   end

endmodule

// File: tb/tb_pulse_len_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_len_gen
// Self-checking bench for pulse_len_gen. The bench has three parts:
//   - A fixed vector table with hand-computed widths and flag timings.
//   - Hand-written sequences for reset (including reset in the middle of a
//     pulse) and, when PL_HOLDOFF_EN is defined, holdoff.
//   - Random launches checked cycle by cycle against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_pulse_len_gen;

   localparam int HOLDOFF_P = 16;
`ifdef PL_HOLDOFF_EN
   localparam int HOLD_CYC = HOLDOFF_P;
`else
   localparam int HOLD_CYC = 0;
`endif

   logic        clk_Pulse;
   logic        rst_n;
   logic        PL_launch;
   logic [16:0] pulse_len;
   logic [4:0]  pl_mlt;
   logic        PL_out;
   logic        End_Flg_PL;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   bit pl_q[$];
   bit end_q[$];
   bit busy_q[$];

   typedef struct {
      int len;
      int mlt;
      int hold;
      bit mid;
      int exp_width;
      int exp_end;
      int exp_end_first;
      int exp_busy;
   } vec_t;

   vec_t vecs[9];

   pulse_len_gen #(.HOLDOFF(HOLDOFF_P)) dut (
      .clk_Pulse  (clk_Pulse),
      .rst_n      (rst_n),
      .PL_launch  (PL_launch),
      .pulse_len  (pulse_len),
      .pl_mlt     (pl_mlt),
      .PL_out     (PL_out),
      .End_Flg_PL (End_Flg_PL),
      .busy       (busy)
   );

   // Free-running clock, period 10.
   initial begin
      clk_Pulse = 1'b0;
      forever #5 clk_Pulse = ~clk_Pulse;
   end

   // Cycle count of one length unit for a given scale code.
   function automatic longint scaleOf(input int mlt);
      if (mlt == 1)      return 1;
      else if (mlt == 2) return 100;
      else               return 100000;
   endfunction

   // Compare one observed value against its expectation and count the result.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Launch one pulse. This task must be called right after a negedge.
   // PL_launch stays high for 'hold' sampled edges and then low for 'gap'
   // edges. One trace sample is taken per cycle, away from the rising edge.
   task automatic applyStimulus(input int len, input int mlt, input int hold,
                                input int gap, input bit mid);
      pl_q.delete();
      end_q.delete();
      busy_q.delete();
      pulse_len = 17'(len);
      pl_mlt    = 5'(mlt);
      PL_launch = 1'b1;
      for (int j = 0; j < hold + gap; j++) begin
         @(posedge clk_Pulse);
         @(negedge clk_Pulse);
         pl_q.push_back(PL_out);
         end_q.push_back(End_Flg_PL);
         busy_q.push_back(busy);
         PL_launch = (j + 1 < hold);
         if (mid && j == 2) begin
            pulse_len = 17'd50;
            pl_mlt    = 5'd1;
         end
      end
   endtask

   // Summary checks of the last trace against hand-computed expected values.
   task automatic checkCounts(input string tag, input int width, input int endcnt,
                              input int endfirst, input int busycnt);
      int w, e, ef, b;
      w = 0; e = 0; ef = -1; b = 0;
      foreach (pl_q[j]) begin
         w += int'(pl_q[j]);
         e += int'(end_q[j]);
         b += int'(busy_q[j]);
         if (end_q[j] && ef < 0) ef = j;
      end
      checkOutput({tag, " PL_out width"}, w, width);
      checkOutput({tag, " End_Flg_PL cycles"}, e, endcnt);
      checkOutput({tag, " End_Flg_PL first"}, ef, endfirst);
      checkOutput({tag, " busy cycles"}, b, busycnt + HOLD_CYC);
   endtask

   // Reference model. Sample j is taken after launch edge k+j. The pulse runs
   // for N = len*scale cycles unless it is cut short by dropping the launch
   // level after 'hold' cycles. The flag covers the stretch between completion
   // and the launch level dropping. busy covers the whole time the launch
   // level is high, plus the holdoff time.
   task automatic compareModel(input string tag, input int len, input int mlt, input int hold);
      longint n;
      longint j;
      bit exp_pl, exp_end, exp_busy;
      int bad_pl, bad_end, bad_busy;
      int first_pl, first_end, first_busy;
      n = longint'(len) * scaleOf(mlt);
      bad_pl = 0; bad_end = 0; bad_busy = 0;
      first_pl = -1; first_end = -1; first_busy = -1;
      for (int i = 0; i < pl_q.size(); i++) begin
         j        = longint'(i);
         exp_pl   = (j < n) && (j < longint'(hold));
         exp_end  = (longint'(hold) > n) && (j >= n) && (j < longint'(hold));
         exp_busy = (j < longint'(hold + HOLD_CYC));
         if (pl_q[i] != exp_pl) begin
            bad_pl++;
            if (first_pl < 0) first_pl = i;
         end
         if (end_q[i] != exp_end) begin
            bad_end++;
            if (first_end < 0) first_end = i;
         end
         if (busy_q[i] != exp_busy) begin
            bad_busy++;
            if (first_busy < 0) first_busy = i;
         end
      end
      checks += 3;
      if (bad_pl != 0) begin
         failures++;
         $display("[TB] FAIL %s PL_out trace: %0d wrong cycles, first at %0d (got %0d, expected %0d) len=%0d mlt=%0d hold=%0d",
                  tag, bad_pl, first_pl, pl_q[first_pl], !pl_q[first_pl], len, mlt, hold);
      end
      if (bad_end != 0) begin
         failures++;
         $display("[TB] FAIL %s End_Flg_PL trace: %0d wrong cycles, first at %0d (got %0d, expected %0d) len=%0d mlt=%0d hold=%0d",
                  tag, bad_end, first_end, end_q[first_end], !end_q[first_end], len, mlt, hold);
      end
      if (bad_busy != 0) begin
         failures++;
         $display("[TB] FAIL %s busy trace: %0d wrong cycles, first at %0d (got %0d, expected %0d) len=%0d mlt=%0d hold=%0d",
                  tag, bad_busy, first_busy, busy_q[first_busy], !busy_q[first_busy], len, mlt, hold);
      end
   endtask

   // Main sequence: reset, table vectors, mid-pulse reset, holdoff, random.
   initial begin
      int pl_cnt, busy_cnt, end_cnt;
      int len, mlt, hold, gap, sel;
      longint n;

      // Fields: len, mlt, hold, mid, width, end cycles, end first, busy (without holdoff)
      vecs[0] = '{10, 1,  15, 1'b0,  10,  5,  10,  15};
      vecs[1] = '{ 3, 2, 310, 1'b1, 300, 10, 300, 310};
      vecs[2] = '{ 0, 7,   4, 1'b0,   0,  4,   0,   4};
      vecs[3] = '{100, 1, 40, 1'b0,  40,  0,  -1,  40};
      vecs[4] = '{ 5, 1,   5, 1'b0,   5,  0,  -1,   5};
      vecs[5] = '{ 5, 1,   6, 1'b0,   5,  1,   5,   6};
      vecs[6] = '{ 1, 1,   3, 1'b0,   1,  2,   1,   3};
      vecs[7] = '{ 0, 2,   1, 1'b0,   0,  1,   0,   1};
      vecs[8] = '{ 7, 2, 705, 1'b0, 700,  5, 700, 705};

      rst_n     = 1'b0;
      PL_launch = 1'b0;
      pulse_len = '0;
      pl_mlt    = 5'd1;
      #12;
      checkOutput("reset PL_out", int'(PL_out), 0);
      checkOutput("reset End_Flg_PL", int'(End_Flg_PL), 0);
      checkOutput("reset busy", int'(busy), 0);
      @(negedge clk_Pulse);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_Pulse);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].len, vecs[i].mlt, vecs[i].hold, 3 + HOLD_CYC, vecs[i].mid);
         checkCounts($sformatf("vec%0d", i), vecs[i].exp_width, vecs[i].exp_end,
                     vecs[i].exp_end_first, vecs[i].exp_busy);
      end

      pulse_len = 17'd10;
      pl_mlt    = 5'd1;
      PL_launch = 1'b1;
      repeat (5) @(posedge clk_Pulse);
      #1;
      checkOutput("midreset PL_out before", int'(PL_out), 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset PL_out", int'(PL_out), 0);
      checkOutput("midreset End_Flg_PL", int'(End_Flg_PL), 0);
      checkOutput("midreset busy", int'(busy), 0);
      @(negedge clk_Pulse);
      rst_n = 1'b1;
      pl_cnt = 0; busy_cnt = 0; end_cnt = 0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk_Pulse);
         pl_cnt   += int'(PL_out);
         busy_cnt += int'(busy);
         end_cnt  += int'(End_Flg_PL);
      end
      checkOutput("postreset held-high PL_out cycles", pl_cnt, 0);
      checkOutput("postreset held-high busy cycles", busy_cnt, 0);
      checkOutput("postreset held-high End_Flg_PL cycles", end_cnt, 0);
      PL_launch = 1'b0;
      @(negedge clk_Pulse);
      applyStimulus(10, 1, 12, 3 + HOLD_CYC, 1'b0);
      checkCounts("postreset fresh", 10, 2, 10, 12);

`ifdef PL_HOLDOFF_EN
      applyStimulus(4, 1, 6, 5, 1'b0);
      PL_launch = 1'b1;
      pl_cnt = 0; busy_cnt = 0;
      for (int j = 0; j < 30; j++) begin
         @(posedge clk_Pulse);
         @(negedge clk_Pulse);
         pl_cnt   += int'(PL_out);
         busy_cnt += int'(busy);
         if (j == 0) checkOutput("holdoff busy in HOLD", int'(busy), 1);
      end
      checkOutput("holdoff early PL_out cycles", pl_cnt, 0);
      checkOutput("holdoff early busy cycles", busy_cnt, 11);
      PL_launch = 1'b0;
      repeat (20) @(negedge clk_Pulse);
      applyStimulus(4, 1, 6, HOLD_CYC + 1, 1'b0);
      compareModel("holdoff late", 4, 1, 6);
`endif

      for (int t = 0; t < 30; t++) begin
         sel = int'($urandom_range(0, 4));
         if (sel <= 1) begin
            mlt = 1;
            len = int'($urandom_range(0, 20));
         end else if (sel <= 3) begin
            mlt = 2;
            len = int'($urandom_range(0, 3));
         end else begin
            mlt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 31));
            len = 0;
         end
         n    = longint'(len) * scaleOf(mlt);
         hold = int'($urandom_range(1, 32'(n) + 5));
         gap  = int'($urandom_range(1, 3)) + HOLD_CYC;
         applyStimulus(len, mlt, hold, gap, t[0]);
         compareModel($sformatf("rand%0d", t), len, mlt, hold);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
